// File: rtl/reg_file_demux_if.sv
// Register-file bus: write side (1-to-8 demux input), two read ports and
// write-commit status.
interface reg_file_demux_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
);
   logic signed [DATA_WIDTH-1:0] IN;
   logic        [ADDR_WIDTH-1:0] INADDRESS;
   logic                         WRITE;
   logic                         BUSYWAIT;
   logic        [ADDR_WIDTH-1:0] OUT1ADDRESS;
   logic        [ADDR_WIDTH-1:0] OUT2ADDRESS;
   logic signed [DATA_WIDTH-1:0] OUT1;
   logic signed [DATA_WIDTH-1:0] OUT2;
   logic                         WRITE_DONE;
   logic        [ADDR_WIDTH-1:0] LAST_WADDR;

   modport master (
      output IN, INADDRESS, WRITE, BUSYWAIT, OUT1ADDRESS, OUT2ADDRESS,
      input  OUT1, OUT2, WRITE_DONE, LAST_WADDR
   );

   modport slave (
      input  IN, INADDRESS, WRITE, BUSYWAIT, OUT1ADDRESS, OUT2ADDRESS,
      output OUT1, OUT2, WRITE_DONE, LAST_WADDR
   );
endinterface

// File: rtl/reg_file_demux.sv
// 8 x 8-bit register file: one demuxed write port, two combinational read
// ports, and a registered write-acknowledge pulse with last written address.
module reg_file_demux #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic             CLK,
   input  logic             RESET,
   reg_file_demux_if.slave  bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0]      wr_sel;
   logic                  commit;

   assign commit = bus.WRITE & ~bus.BUSYWAIT;

   // One-hot decoder: an unknown enable can only reach the addressed register.
   for (genvar i = 0; i < DEPTH; i++) begin : g_dec
      assign wr_sel[i] = commit & (bus.INADDRESS == ADDR_WIDTH'(i));
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++)
            if (wr_sel[i]) regs[i] <= bus.IN;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         bus.WRITE_DONE <= 1'b0;
         bus.LAST_WADDR <= '0;
      end else begin
         bus.WRITE_DONE <= commit;
         if (commit) bus.LAST_WADDR <= bus.INADDRESS;
      end
   end

   // No bypass: reads see the stored array only.
   assign bus.OUT1 = regs[bus.OUT1ADDRESS];
   assign bus.OUT2 = regs[bus.OUT2ADDRESS];
endmodule
